core_sequencer: RTL

//  Parametrised control sequencer for a SIMD compute core; replaces the hard-coded 3-state core FSM.

---
 rtl/core_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : core_sequencer
// Purpose  : Control sequencer for a SIMD compute core. It drives fetch, LSU
//            issue/completion tracking, per-thread writes and branches.
// Revision : 1.0
// ============================================================================
module core_sequencer #(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int ALU_LATENCY           = 1,
    parameter int WATCHDOG_BITS         = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]     thread_count,
    output logic                                   done,
    output logic                                   error,
    output logic                                   fetch_valid,
    input  logic                                   fetch_ready,
    input  logic                                   is_branch,
    input  logic                                   is_ldr,
    input  logic                                   is_str,
    input  logic                                   is_write,
    input  logic                                   is_halt,
    input  logic [2:0]                             nzp_cond,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0]       branch_target,
    input  logic [3*THREADS_PER_BLOCK-1:0]         nzp,
    output logic [THREADS_PER_BLOCK-1:0]           lsu_req,
    input  logic [THREADS_PER_BLOCK-1:0]           lsu_done,
    output logic [THREADS_PER_BLOCK-1:0]           reg_we,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]       pc,
    output logic [2:0]                             state
);

    localparam int T   = THREADS_PER_BLOCK;
    localparam int AW  = PROGRAM_MEM_ADDR_BITS;
    localparam int CW  = $clog2(THREADS_PER_BLOCK) + 1;
    localparam int WDB = WATCHDOG_BITS;
    localparam int ALW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    localparam logic [ALW-1:0] C_ALU_LOAD = ALW'(ALU_LATENCY - 1);
    // The cycle whose increment would reach all-ones is the last run cycle.
    localparam logic [WDB-1:0] C_WD_LAST  = {{(WDB-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_WAIT    = 3'd4,
        S_UPDATE  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_pc;
    logic             r_done;
    logic             r_error;
    logic             r_fetch_valid;
    logic [T-1:0]     r_lsu_req;
    logic [T-1:0]     r_reg_we;
    logic [T-1:0]     r_active;
    logic [T-1:0]     r_pending;
    logic             r_writes;
    logic [ALW-1:0]   r_alu_cnt;
    logic [WDB-1:0]   r_wdog;

    logic [T-1:0]     w_mask;
    logic [T-1:0]     w_pend_next;
    logic             w_lane_hit;
    logic             w_taken;
    logic             w_in_run;

    // Lane t is active when thread_count > t, which also clamps counts above T.
    always_comb begin
        w_mask     = '0;
        w_lane_hit = 1'b0;
        for (int t = 0; t < T; t++) begin
            w_mask[t] = (thread_count > CW'(t));
            if (r_active[t] && (|(nzp[3*t +: 3] & nzp_cond))) begin
                w_lane_hit = 1'b1;
            end
        end
    end

    assign w_taken     = is_branch & w_lane_hit;
    assign w_pend_next = r_pending & ~lsu_done;
    assign w_in_run    = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                         (r_state == S_EXECUTE) || (r_state == S_WAIT) ||
                         (r_state == S_UPDATE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_lsu_req     <= '0;
            r_reg_we      <= '0;
            r_active      <= '0;
            r_pending     <= '0;
            r_writes      <= 1'b0;
            r_alu_cnt     <= '0;
            r_wdog        <= '0;
        end else begin
            r_lsu_req <= '0;
            r_reg_we  <= '0;
            if (w_in_run && (r_wdog == C_WD_LAST)) begin
                r_state       <= S_DONE;
                r_done        <= 1'b1;
                r_error       <= 1'b1;
                r_fetch_valid <= 1'b0;
                r_pending     <= '0;
            end else begin
                if (w_in_run) begin
                    r_wdog <= r_wdog + 1'b1;
                end
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_active <= w_mask;
                            r_error  <= 1'b0;
                            if (thread_count == '0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state       <= S_FETCH;
                                r_pc          <= '0;
                                r_wdog        <= '0;
                                r_fetch_valid <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: begin
                        if (fetch_ready) begin
                            r_state       <= S_DECODE;
                            r_fetch_valid <= 1'b0;
                        end
                    end
                    S_DECODE: begin
                        r_state   <= S_EXECUTE;
                        r_alu_cnt <= C_ALU_LOAD;
                    end
                    S_EXECUTE: begin
                        if (is_halt) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_error <= 1'b0;
                        end else if (is_ldr || is_str) begin
                            r_state   <= S_WAIT;
                            r_lsu_req <= r_active;
                            r_pending <= r_active;
                            r_writes  <= is_ldr & ~is_str;
                        end else if (r_alu_cnt == '0) begin
                            r_state  <= S_UPDATE;
                            r_reg_we <= is_write ? r_active : '0;
                        end else begin
                            r_alu_cnt <= r_alu_cnt - 1'b1;
                        end
                    end
                    S_WAIT: begin
                        r_pending <= w_pend_next;
                        if (w_pend_next == '0) begin
                            r_state  <= S_UPDATE;
                            r_reg_we <= r_writes ? r_active : '0;
                        end
                    end
                    S_UPDATE: begin
                        r_state       <= S_FETCH;
                        r_fetch_valid <= 1'b1;
                        r_pc          <= w_taken ? branch_target : r_pc + 1'b1;
                    end
                    S_DONE: begin
                        if (!start) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign state       = r_state;
    assign pc          = r_pc;
    assign done        = r_done;
    assign error       = r_error;
    assign fetch_valid = r_fetch_valid;
    assign lsu_req     = r_lsu_req;
    assign reg_we      = r_reg_we;

endmodule
`default_nettype wire
